// File: rtl/axi_s_pkg.sv
// rtl/axi_s_pkg.sv - shared types and constants for the AXI-stream packet path
package axi_s_pkg;

  // Default beat width of the packet path.
  localparam int AXI_S_DATA_WIDTH = 64;

  // Packet-level arbitration state of the inline inserter.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAIN = 2'd1,
    INS  = 2'd2
  } inserter_state_e;

  // Encoding of the source that won the most recent grant.
  localparam logic GRANT_MAIN = 1'b0;
  localparam logic GRANT_INS  = 1'b1;

  // Width of a packed {tdata, tkeep, tlast} beat for a given tdata width.
  function automatic int payload_width(input int data_width);
    return data_width + (data_width / 8) + 1;
  endfunction

endpackage

// File: rtl/axi_s_skid_buffer.sv
// rtl/axi_s_skid_buffer.sv - two-register skid stage with registered input-side ready
module axi_s_skid_buffer
  import axi_s_pkg::*;
#(
  parameter int  DATA_WIDTH    = AXI_S_DATA_WIDTH,
  localparam int PAYLOAD_WIDTH = DATA_WIDTH + (DATA_WIDTH / 8) + 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [PAYLOAD_WIDTH-1:0] s_payload,
  input  logic                     s_valid,
  output logic                     s_ready,
  output logic [PAYLOAD_WIDTH-1:0] m_payload,
  output logic                     m_valid,
  input  logic                     m_ready
);

  logic                     s_ready_q, s_ready_d;
  logic                     m_valid_q, m_valid_d;
  logic [PAYLOAD_WIDTH-1:0] m_payload_q, m_payload_d;
  logic                     skid_valid_q, skid_valid_d;
  logic [PAYLOAD_WIDTH-1:0] skid_payload_q, skid_payload_d;
  logic                     s_fire;

  assign s_fire    = s_valid && s_ready_q;
  assign s_ready   = s_ready_q;
  assign m_valid   = m_valid_q;
  assign m_payload = m_payload_q;

  // Refill the output register from the skid beat first, else from the input; park the input in the skid when stalled.
  always_comb begin
    m_valid_d      = m_valid_q;
    m_payload_d    = m_payload_q;
    skid_valid_d   = skid_valid_q;
    skid_payload_d = skid_payload_q;
    if (!m_valid_q || m_ready) begin
      if (skid_valid_q) begin
        m_valid_d    = 1'b1;
        m_payload_d  = skid_payload_q;
        skid_valid_d = 1'b0;
      end else if (s_fire) begin
        m_valid_d   = 1'b1;
        m_payload_d = s_payload;
      end else begin
        m_valid_d = 1'b0;
      end
    end else if (s_fire) begin
      skid_valid_d   = 1'b1;
      skid_payload_d = s_payload;
    end
    // Accept new input only while the overflow register will be free.
    s_ready_d = !skid_valid_d;
  end

  // Control flops: reset empties both registers and opens the input.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_ready_q    <= 1'b1;
      m_valid_q    <= 1'b0;
      skid_valid_q <= 1'b0;
    end else begin
      s_ready_q    <= s_ready_d;
      m_valid_q    <= m_valid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  // Payload flops carry no reset; their contents are qualified by the valid flags.
  always_ff @(posedge clk) begin
    m_payload_q    <= m_payload_d;
    skid_payload_q <= skid_payload_d;
  end

endmodule

// File: rtl/axi_s_inline_inserter.sv
// rtl/axi_s_inline_inserter.sv - merges whole insert-stream packets into the main stream at packet boundaries
module axi_s_inline_inserter
  import axi_s_pkg::*;
#(
  parameter int  DATA_WIDTH = AXI_S_DATA_WIDTH,
  localparam int KEEP_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  insert_en,

  input  logic [DATA_WIDTH-1:0] s_packet_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s_packet_axis_tkeep,
  input  logic                  s_packet_axis_tlast,
  input  logic                  s_packet_axis_tvalid,
  output logic                  s_packet_axis_tready,

  input  logic [DATA_WIDTH-1:0] s_insert_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s_insert_axis_tkeep,
  input  logic                  s_insert_axis_tlast,
  input  logic                  s_insert_axis_tvalid,
  output logic                  s_insert_axis_tready,

  output logic [DATA_WIDTH-1:0] m_packet_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_packet_axis_tkeep,
  output logic                  m_packet_axis_tlast,
  output logic                  m_packet_axis_tvalid,
  input  logic                  m_packet_axis_tready,

  output logic [31:0]           main_pkt_count,
  output logic [31:0]           ins_pkt_count
);

  localparam int PAYLOAD_WIDTH = DATA_WIDTH + KEEP_WIDTH + 1;

  inserter_state_e          state_q, state_d;
  logic                     last_grant_q, last_grant_d;
  logic [31:0]              main_pkt_count_q, main_pkt_count_d;
  logic [31:0]              ins_pkt_count_q, ins_pkt_count_d;

  logic                     sel_active;
  logic                     sel_ins;
  logic                     src_valid;
  logic                     src_last;
  logic [PAYLOAD_WIDTH-1:0] src_payload;
  logic                     skid_s_ready;
  logic                     beat_fire;
  logic [PAYLOAD_WIDTH-1:0] skid_m_payload;

  // Pick the source that owns the path: a fresh grant in IDLE, otherwise the packet in progress.
  always_comb begin
    sel_active = 1'b0;
    sel_ins    = 1'b0;
    case (state_q)
      IDLE: begin
        if (insert_en && s_insert_axis_tvalid &&
            (last_grant_q == GRANT_MAIN || !s_packet_axis_tvalid)) begin
          sel_active = 1'b1;
          sel_ins    = 1'b1;
        end else if (s_packet_axis_tvalid) begin
          sel_active = 1'b1;
        end
      end
      MAIN: begin
        sel_active = 1'b1;
      end
      INS: begin
        sel_active = 1'b1;
        sel_ins    = 1'b1;
      end
      default: begin
        sel_active = 1'b0;
      end
    endcase
  end

  // Input mux: forward the selected source's beat untouched into the skid stage.
  always_comb begin
    src_valid   = 1'b0;
    src_last    = 1'b0;
    src_payload = {s_packet_axis_tdata, s_packet_axis_tkeep, s_packet_axis_tlast};
    if (sel_active && !rst) begin
      src_valid = sel_ins ? s_insert_axis_tvalid : s_packet_axis_tvalid;
    end
    if (sel_ins) begin
      src_last    = s_insert_axis_tlast;
      src_payload = {s_insert_axis_tdata, s_insert_axis_tkeep, s_insert_axis_tlast};
    end else begin
      src_last = s_packet_axis_tlast;
    end
  end

  assign beat_fire = src_valid && skid_s_ready;

  // Only the owning source sees the skid ready; held low throughout reset.
  assign s_packet_axis_tready = !rst && sel_active && !sel_ins && skid_s_ready;
  assign s_insert_axis_tready = !rst && sel_active && sel_ins && skid_s_ready;

  // Commit a grant only when its first beat moves; a tlast beat closes the packet and bumps its counter.
  always_comb begin
    state_d          = state_q;
    last_grant_d     = last_grant_q;
    main_pkt_count_d = main_pkt_count_q;
    ins_pkt_count_d  = ins_pkt_count_q;
    if (state_q != IDLE && state_q != MAIN && state_q != INS) begin
      state_d = IDLE;
    end
    if (beat_fire) begin
      if (state_q == IDLE) begin
        last_grant_d = sel_ins ? GRANT_INS : GRANT_MAIN;
      end
      if (src_last) begin
        state_d = IDLE;
        if (sel_ins) begin
          ins_pkt_count_d = ins_pkt_count_q + 32'd1;
        end else begin
          main_pkt_count_d = main_pkt_count_q + 32'd1;
        end
      end else begin
        state_d = sel_ins ? INS : MAIN;
      end
    end
  end

  // State and counters; last_grant resets to INS so the main stream wins the first contention.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= IDLE;
      last_grant_q     <= GRANT_INS;
      main_pkt_count_q <= 32'd0;
      ins_pkt_count_q  <= 32'd0;
    end else begin
      state_q          <= state_d;
      last_grant_q     <= last_grant_d;
      main_pkt_count_q <= main_pkt_count_d;
      ins_pkt_count_q  <= ins_pkt_count_d;
    end
  end

  assign main_pkt_count = main_pkt_count_q;
  assign ins_pkt_count  = ins_pkt_count_q;

  axi_s_skid_buffer #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_skid (
    .clk      (clk),
    .rst      (rst),
    .s_payload(src_payload),
    .s_valid  (src_valid),
    .s_ready  (skid_s_ready),
    .m_payload(skid_m_payload),
    .m_valid  (m_packet_axis_tvalid),
    .m_ready  (m_packet_axis_tready)
  );

  assign {m_packet_axis_tdata, m_packet_axis_tkeep, m_packet_axis_tlast} = skid_m_payload;

endmodule

// File: tb/tb_axi_s_inline_inserter.sv
// tb/tb_axi_s_inline_inserter.sv - self-checking bench for the inline packet inserter
module tb_axi_s_inline_inserter;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        insert_en;
  logic [63:0] s_packet_axis_tdata;
  logic [7:0]  s_packet_axis_tkeep;
  logic        s_packet_axis_tlast;
  logic        s_packet_axis_tvalid;
  logic        s_packet_axis_tready;
  logic [63:0] s_insert_axis_tdata;
  logic [7:0]  s_insert_axis_tkeep;
  logic        s_insert_axis_tlast;
  logic        s_insert_axis_tvalid;
  logic        s_insert_axis_tready;
  logic [63:0] m_packet_axis_tdata;
  logic [7:0]  m_packet_axis_tkeep;
  logic        m_packet_axis_tlast;
  logic        m_packet_axis_tvalid;
  logic        m_packet_axis_tready = 1'b1;
  logic [31:0] main_pkt_count;
  logic [31:0] ins_pkt_count;

  beat_t main_q[$];
  beat_t ins_q[$];
  beat_t exp_q[$];

  int n_vec = 0;
  int n_bad = 0;
  int exp_main = 0;
  int exp_ins = 0;
  int cyc = 0;
  int out_cnt = 0;
  int first_out_cyc = 0;
  int last_out_cyc = 0;
  bit bp_on = 1'b0;
  bit ins_low_chk = 1'b0;
  bit stalled_prev = 1'b0;
  beat_t prev_beat;

  axi_s_inline_inserter dut (
    .clk                 (clk),
    .rst                 (rst),
    .insert_en           (insert_en),
    .s_packet_axis_tdata (s_packet_axis_tdata),
    .s_packet_axis_tkeep (s_packet_axis_tkeep),
    .s_packet_axis_tlast (s_packet_axis_tlast),
    .s_packet_axis_tvalid(s_packet_axis_tvalid),
    .s_packet_axis_tready(s_packet_axis_tready),
    .s_insert_axis_tdata (s_insert_axis_tdata),
    .s_insert_axis_tkeep (s_insert_axis_tkeep),
    .s_insert_axis_tlast (s_insert_axis_tlast),
    .s_insert_axis_tvalid(s_insert_axis_tvalid),
    .s_insert_axis_tready(s_insert_axis_tready),
    .m_packet_axis_tdata (m_packet_axis_tdata),
    .m_packet_axis_tkeep (m_packet_axis_tkeep),
    .m_packet_axis_tlast (m_packet_axis_tlast),
    .m_packet_axis_tvalid(m_packet_axis_tvalid),
    .m_packet_axis_tready(m_packet_axis_tready),
    .main_pkt_count      (main_pkt_count),
    .ins_pkt_count       (ins_pkt_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Downstream ready: constant 1, or a 50% coin flip per cycle when backpressure is on.
  always @(posedge clk) begin
    #1;
    m_packet_axis_tready = bp_on ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic beat_t mk_beat(input bit is_ins, input int id, input int b, input int n,
                                    input logic [7:0] last_keep);
    beat_t r;
    r.data = {(is_ins ? 16'h1A5E : 16'hAA17), 16'(id), 16'(b), 16'h5EED};
    r.last = (b == n - 1);
    r.keep = r.last ? last_keep : 8'hFF;
    return r;
  endfunction

  // Queue a packet on a source and/or append it to the expected output order.
  task automatic add_pkt(input bit is_ins, input int id, input int n, input logic [7:0] last_keep,
                         input bit to_src, input bit to_exp);
    for (int b = 0; b < n; b++) begin
      if (to_src && is_ins) ins_q.push_back(mk_beat(is_ins, id, b, n, last_keep));
      if (to_src && !is_ins) main_q.push_back(mk_beat(is_ins, id, b, n, last_keep));
      if (to_exp) exp_q.push_back(mk_beat(is_ins, id, b, n, last_keep));
    end
    if (to_exp && is_ins) exp_ins++;
    if (to_exp && !is_ins) exp_main++;
  endtask

  // Present queued beats on one source, holding each until it is taken; bounded per beat.
  task automatic drive_src(input bit is_ins, input int budget);
    beat_t b;
    int    waited;
    bit    rdy;
    while ((is_ins ? ins_q.size() : main_q.size()) != 0) begin
      b = is_ins ? ins_q[0] : main_q[0];
      if (is_ins) begin
        s_insert_axis_tdata  = b.data;
        s_insert_axis_tkeep  = b.keep;
        s_insert_axis_tlast  = b.last;
        s_insert_axis_tvalid = 1'b1;
      end else begin
        s_packet_axis_tdata  = b.data;
        s_packet_axis_tkeep  = b.keep;
        s_packet_axis_tlast  = b.last;
        s_packet_axis_tvalid = 1'b1;
      end
      waited = 0;
      while (1) begin
        @(negedge clk);
        rdy = is_ins ? s_insert_axis_tready : s_packet_axis_tready;
        @(posedge clk);
        #1;
        if (rdy) break;
        waited++;
        if (waited > budget) break;
      end
      if (!rdy) begin
        n_vec++;
        n_bad++;
        $display("FAIL src_timeout: source %0d beat not accepted within %0d cycles", is_ins, budget);
        if (is_ins) ins_q.delete();
        else main_q.delete();
      end else begin
        if (is_ins) void'(ins_q.pop_front());
        else void'(main_q.pop_front());
      end
    end
    if (is_ins) s_insert_axis_tvalid = 1'b0;
    else s_packet_axis_tvalid = 1'b0;
  endtask

  task automatic wait_drain(input int budget, input string name);
    int k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      @(posedge clk);
      k++;
    end
    check(name, exp_q.size(), 0);
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    s_packet_axis_tvalid = 1'b0;
    s_insert_axis_tvalid = 1'b0;
    insert_en = 1'b0;
    main_q.delete();
    ins_q.delete();
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    exp_main = 0;
    exp_ins = 0;
    out_cnt = 0;
  endtask

  // Scoreboard: every output handshake must match the next expected beat; stalled beats must hold.
  always @(negedge clk) begin
    beat_t act;
    act = {m_packet_axis_tdata, m_packet_axis_tkeep, m_packet_axis_tlast};
    if (rst) begin
      stalled_prev = 1'b0;
    end else begin
      if (stalled_prev) check("stall_hold", {m_packet_axis_tvalid, act}, {1'b1, prev_beat});
      if (ins_low_chk) check("ins_ready_low", s_insert_axis_tready, 0);
      if (m_packet_axis_tvalid && m_packet_axis_tready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", act, 0);
        end else begin
          check("out_beat", act, exp_q.pop_front());
        end
        out_cnt++;
        if (out_cnt == 1) first_out_cyc = cyc;
        last_out_cyc = cyc;
      end
      stalled_prev = m_packet_axis_tvalid && !m_packet_axis_tready;
      prev_beat = act;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    insert_en = 1'b1;
    s_packet_axis_tdata = '0;
    s_packet_axis_tkeep = '0;
    s_packet_axis_tlast = 1'b0;
    s_packet_axis_tvalid = 1'b1;
    s_insert_axis_tdata = '0;
    s_insert_axis_tkeep = '0;
    s_insert_axis_tlast = 1'b0;
    s_insert_axis_tvalid = 1'b1;

    // Reset state, with both sources requesting.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_m_tvalid", m_packet_axis_tvalid, 0);
    check("rst_pkt_ready", s_packet_axis_tready, 0);
    check("rst_ins_ready", s_insert_axis_tready, 0);
    check("rst_main_cnt", main_pkt_count, 0);
    check("rst_ins_cnt", ins_pkt_count, 0);
    do_reset();

    // Main only with insert_en=0 while the insert stream waits.
    s_insert_axis_tdata = 64'hDEAD_BEEF_0000_0001;
    s_insert_axis_tkeep = 8'hFF;
    s_insert_axis_tlast = 1'b1;
    s_insert_axis_tvalid = 1'b1;
    ins_low_chk = 1'b1;
    add_pkt(0, 4, 3, 8'h0F, 1, 1);
    fork
      drive_src(0, 20);
      begin
        @(negedge clk);
        check("t1_no_early", m_packet_axis_tvalid, 0);
        @(negedge clk);
        check("t1_lat_valid", m_packet_axis_tvalid, 1);
        check("t1_lat_data", m_packet_axis_tdata, 64'hAA17_0004_0000_5EED);
        @(negedge clk);
        @(negedge clk);
        check("t1_last_keep", {m_packet_axis_tkeep, m_packet_axis_tlast}, {8'h0F, 1'b1});
      end
    join
    wait_drain(20, "t1_drain");
    check("t1_main_cnt", main_pkt_count, exp_main);
    check("t1_ins_cnt", ins_pkt_count, 0);
    check("t1_span", last_out_cyc - first_out_cyc + 1, out_cnt);
    ins_low_chk = 1'b0;
    s_insert_axis_tvalid = 1'b0;

    // Contention: alternating 2-beat packets with no idle cycles.
    do_reset();
    insert_en = 1'b1;
    for (int k = 0; k < 2; k++) begin
      add_pkt(0, k, 2, 8'hFF, 1, 1);
      add_pkt(1, k, 2, 8'h07, 1, 1);
    end
    fork
      drive_src(0, 40);
      drive_src(1, 40);
    join
    wait_drain(20, "t2_drain");
    check("t2_main_cnt", main_pkt_count, 32'd2);
    check("t2_ins_cnt", ins_pkt_count, 32'd2);
    check("t2_beats", out_cnt, 8);
    check("t2_span", last_out_cyc - first_out_cyc + 1, out_cnt);

    // Insert arrives mid-way through a 4-beat main packet and follows immediately.
    do_reset();
    insert_en = 1'b1;
    add_pkt(0, 30, 4, 8'h3F, 1, 1);
    add_pkt(1, 31, 3, 8'h01, 1, 1);
    fork
      drive_src(0, 20);
      begin
        repeat (2) @(posedge clk);
        #1;
        drive_src(1, 20);
      end
    join
    wait_drain(20, "t3_drain");
    check("t3_beats", out_cnt, 7);
    check("t3_span", last_out_cyc - first_out_cyc + 1, out_cnt);
    check("t3_counts", {main_pkt_count, ins_pkt_count}, {32'd1, 32'd1});

    // Random downstream backpressure over 100 beats from both sources.
    do_reset();
    insert_en = 1'b1;
    bp_on = 1'b1;
    for (int k = 0; k < 10; k++) begin
      add_pkt(0, 100 + k, 5, 8'hFF >> (k % 8), 1, 1);
      add_pkt(1, 200 + k, 5, 8'hFF >> ((k + 3) % 8), 1, 1);
    end
    fork
      drive_src(0, 400);
      drive_src(1, 400);
    join
    wait_drain(600, "t4_drain");
    bp_on = 1'b0;
    check("t4_beats", out_cnt, 100);
    check("t4_counts", {main_pkt_count, ins_pkt_count}, {32'd10, 32'd10});

    // insert_en drops after the first beat of an insert packet; the packet finishes, the next waits.
    do_reset();
    insert_en = 1'b1;
    add_pkt(1, 40, 3, 8'hFF, 1, 1);
    fork
      drive_src(1, 20);
      begin
        @(posedge clk);
        #1;
        insert_en = 1'b0;
      end
    join
    s_insert_axis_tdata = 64'h1A5E_0029_0000_5EED;
    s_insert_axis_tkeep = 8'hFF;
    s_insert_axis_tlast = 1'b0;
    s_insert_axis_tvalid = 1'b1;
    ins_low_chk = 1'b1;
    repeat (8) @(posedge clk);
    @(negedge clk);
    check("t5_no_grant", m_packet_axis_tvalid, 0);
    ins_low_chk = 1'b0;
    s_insert_axis_tvalid = 1'b0;
    wait_drain(10, "t5_drain");
    check("t5_ins_cnt", ins_pkt_count, 32'd1);
    check("t5_beats", out_cnt, 3);

    // Reset during beat 2 of a main packet, then a fresh packet.
    do_reset();
    add_pkt(0, 20, 1, 8'h3F, 1, 1);
    drive_src(0, 10);
    wait_drain(10, "t6_pre_drain");
    check("t6_pre_cnt", main_pkt_count, 32'd1);
    s_packet_axis_tdata = 64'hAA17_0015_0000_5EED;
    s_packet_axis_tkeep = 8'hFF;
    s_packet_axis_tlast = 1'b0;
    s_packet_axis_tvalid = 1'b1;
    @(posedge clk);
    #1;
    s_packet_axis_tdata = 64'hAA17_0015_0001_5EED;
    rst = 1'b1;
    @(negedge clk);
    check("t6_ready_in_rst", s_packet_axis_tready, 0);
    @(posedge clk);
    #1;
    s_packet_axis_tvalid = 1'b0;
    @(negedge clk);
    check("t6_flush_valid", m_packet_axis_tvalid, 0);
    check("t6_flush_cnt", main_pkt_count, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_main = 0;
    out_cnt = 0;
    add_pkt(0, 22, 2, 8'hFF, 1, 1);
    fork
      drive_src(0, 10);
      begin
        @(negedge clk);
        @(negedge clk);
        check("t6_fresh_data", {m_packet_axis_tvalid, m_packet_axis_tdata}, {1'b1, 64'hAA17_0016_0000_5EED});
      end
    join
    wait_drain(10, "t6_drain");
    check("t6_post_cnt", main_pkt_count, exp_main);

    // Counter wrap from all-ones.
    do_reset();
    @(negedge clk);
    force dut.main_pkt_count_q = 32'hFFFF_FFFF;
    force dut.ins_pkt_count_q = 32'hFFFF_FFFE;
    @(posedge clk);
    #1;
    release dut.main_pkt_count_q;
    release dut.ins_pkt_count_q;
    add_pkt(0, 50, 1, 8'hFF, 1, 1);
    drive_src(0, 10);
    insert_en = 1'b1;
    add_pkt(1, 51, 1, 8'hFF, 1, 1);
    add_pkt(1, 52, 2, 8'hFF, 1, 1);
    drive_src(1, 10);
    wait_drain(10, "t7_drain");
    check("t7_main_wrap", main_pkt_count, 32'd0);
    check("t7_ins_wrap", ins_pkt_count, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
